// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back control path.
// Optional bypass feature: REGFILE_WB_BYPASS_EN.
package regfile_ctl_pkg;

  localparam int ADDR_DEF     = 5;
  localparam int SIZE_DEF     = 32;
  localparam int NREQ_DEF     = 3;
  localparam int MAX_WAIT_DEF = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef struct packed {
    logic [ADDR_DEF-1:0] rw;
    logic [SIZE_DEF-1:0] data;
  } slot_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between write-back sources, decode and the register-file port.
// Bypass signals exist only when REGFILE_WB_BYPASS_EN is defined.
interface regfile_wb_arbiter_if
  import regfile_ctl_pkg::*;
#(
  parameter int ADDR = ADDR_DEF,
  parameter int SIZE = SIZE_DEF,
  parameter int NREQ = NREQ_DEF
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*ADDR-1:0] req_rw;
  logic [NREQ*SIZE-1:0] req_data;
  logic                 rd_req;
  logic                 rd_grant;
  logic                 OP;
  logic                 WE;
  logic [ADDR-1:0]      RW;
  logic [SIZE-1:0]      busW;
`ifdef REGFILE_WB_BYPASS_EN
  logic [ADDR-1:0]      rd_ra;
  logic [ADDR-1:0]      rd_rb;
  logic                 byp_a_hit;
  logic                 byp_b_hit;
  logic [SIZE-1:0]      byp_a_data;
  logic [SIZE-1:0]      byp_b_data;
`endif

  modport master (
    output req_valid, req_rw, req_data, rd_req,
`ifdef REGFILE_WB_BYPASS_EN
    output rd_ra, rd_rb,
    input  byp_a_hit, byp_b_hit, byp_a_data, byp_b_data,
`endif
    input  req_ready, rd_grant, OP, WE, RW, busW
  );

  modport slave (
    input  req_valid, req_rw, req_data, rd_req,
`ifdef REGFILE_WB_BYPASS_EN
    input  rd_ra, rd_rb,
    output byp_a_hit, byp_b_hit, byp_a_data, byp_b_data,
`endif
    output req_ready, rd_grant, OP, WE, RW, busW
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: first requester at or after i_ptr wins, wrapping.
// Not affected by REGFILE_WB_BYPASS_EN.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_idx;

  // Walk from the farthest offset back to ptr so the closest requester is the last to win.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = |i_req;
    w_idx   = 0;
    for (int off = N - 1; off >= 0; off--) begin
      w_idx = int'(i_ptr) + off;
      if (w_idx >= N) w_idx = w_idx - N;
      if (i_req[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
        o_idx          = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and read/write phase sequencer for the single-port register file.
// Define REGFILE_WB_BYPASS_EN to add decode-side bypass of pending results.
module regfile_wb_arbiter
  import regfile_ctl_pkg::*;
#(
  parameter int ADDR     = ADDR_DEF,
  parameter int SIZE     = SIZE_DEF,
  parameter int NREQ     = NREQ_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [NREQ-1:0] r_held;
  logic [ADDR-1:0] r_rw   [NREQ];
  logic [SIZE-1:0] r_data [NREQ];
  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_starve;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_winIdx;
  logic            w_any;
  logic            w_writeCyc;
  logic [NREQ-1:0] w_accept;
  logic [NREQ-1:0] w_heldNext;

  rr_arbiter #(.N(NREQ)) u_rr (
    .i_req   (r_held),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_winIdx),
    .o_any   (w_any)
  );

  // Writes to r0 are accepted but dropped, so they never occupy a slot.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_accept[i] = bus.req_valid[i] && !r_held[i] && (bus.req_rw[i*ADDR +: ADDR] != '0);
    end
    w_heldNext = (r_held & ~(w_writeCyc ? w_grant : '0)) | w_accept;
  end

  always_comb begin
    w_writeCyc    = w_any && (!bus.rd_req || (r_starve == CW'(MAX_WAIT)));
    bus.OP        = w_writeCyc ? OP_WRITE : OP_READ;
    bus.WE        = w_writeCyc;
    bus.RW        = w_writeCyc ? r_rw[w_winIdx] : '0;
    bus.busW      = w_writeCyc ? r_data[w_winIdx] : '0;
    bus.rd_grant  = !w_writeCyc && bus.rd_req && RST_N;
    bus.req_ready = ~r_held;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_held   <= '0;
      r_ptr    <= '0;
      r_starve <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_rw[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_accept[i]) begin
          r_rw[i]   <= bus.req_rw[i*ADDR +: ADDR];
          r_data[i] <= bus.req_data[i*SIZE +: SIZE];
        end
      end
      r_held <= w_heldNext;
      if (w_writeCyc) begin
        r_ptr    <= (w_winIdx == IW'(NREQ - 1)) ? '0 : w_winIdx + IW'(1);
        r_starve <= '0;
      end else if (!w_any) begin
        r_starve <= '0;
      end else if (bus.rd_req && (r_starve != CW'(MAX_WAIT))) begin
        r_starve <= r_starve + CW'(1);
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Descending scan so the lowest matching slot index wins.
  always_comb begin
    bus.byp_a_hit  = 1'b0;
    bus.byp_b_hit  = 1'b0;
    bus.byp_a_data = '0;
    bus.byp_b_data = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (r_held[i] && (r_rw[i] == bus.rd_ra) && (bus.rd_ra != '0)) begin
        bus.byp_a_hit  = 1'b1;
        bus.byp_a_data = r_data[i];
      end
      if (r_held[i] && (r_rw[i] == bus.rd_rb) && (bus.rd_rb != '0)) begin
        bus.byp_b_hit  = 1'b1;
        bus.byp_b_data = r_data[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; bypass checks run when REGFILE_WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;
  import regfile_ctl_pkg::*;

  logic CLK;
  logic RST_N;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int testCount = 0;
  int failCount = 0;
  slot_t expQ[$];
  logic [SIZE_DEF-1:0] regModel [32];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [ADDR_DEF-1:0] rw,
                               input logic [SIZE_DEF-1:0] data, input bit expectWrite);
    slot_t s;
    bus.req_valid[idx] = 1'b1;
    bus.req_rw[idx*ADDR_DEF +: ADDR_DEF] = rw;
    bus.req_data[idx*SIZE_DEF +: SIZE_DEF] = data;
    s.rw = rw;
    s.data = data;
    if (expectWrite && rw != '0) expQ.push_back(s);
  endtask

  task automatic clearReq();
    bus.req_valid = '0;
  endtask

  task automatic applyReset();
    RST_N = 1'b0;
    clearReq();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    bus.rd_req = 1'b0;
  endtask

  // Every write cycle must match the oldest outstanding expected write.
  always @(negedge CLK) begin
    if (RST_N && bus.WE) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousWE", bus.WE, 1'b0);
      end else begin
        slot_t e;
        e = expQ.pop_front();
        checkOutput("wrRW", bus.RW, e.rw);
        checkOutput("wrBusW", bus.busW, e.data);
        checkOutput("wrOP", bus.OP, 1'b1);
        checkOutput("wrNoGrant", bus.rd_grant, 1'b0);
        regModel[bus.RW] = bus.busW;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) regModel[i] = '0;
    RST_N = 1'b0;
    bus.req_valid = '0;
    bus.req_rw = '0;
    bus.req_data = '0;
    bus.rd_req = 1'b1;
`ifdef REGFILE_WB_BYPASS_EN
    bus.rd_ra = '0;
    bus.rd_rb = '0;
`endif
    #12;
    checkOutput("rstReady", bus.req_ready, 3'b111);
    checkOutput("rstWE", bus.WE, 1'b0);
    checkOutput("rstOP", bus.OP, 1'b0);
    checkOutput("rstGrant", bus.rd_grant, 1'b0);
    checkOutput("rstRW", bus.RW, 0);
    checkOutput("rstBusW", bus.busW, 0);
    applyReset();

    // Single write, best-case latency
    applyStimulus(0, 5'd5, 32'hDEADBEEF, 1'b1);
    @(posedge CLK); #1;
    clearReq();
    checkOutput("t1WE", bus.WE, 1'b1);
    checkOutput("t1RW", bus.RW, 5);
    checkOutput("t1BusW", bus.busW, 32'hDEADBEEF);
    checkOutput("t1Busy", bus.req_ready[0], 1'b0);
    @(posedge CLK); #1;
    checkOutput("t1Ready", bus.req_ready[0], 1'b1);
    checkOutput("t1Idle", bus.WE, 1'b0);
    checkOutput("t1Reg5", regModel[5], 32'hDEADBEEF);

    // Three simultaneous requesters from ptr=0
    applyReset();
    applyStimulus(0, 5'd1, 32'h11, 1'b1);
    applyStimulus(1, 5'd2, 32'h22, 1'b1);
    applyStimulus(2, 5'd3, 32'h33, 1'b1);
    @(posedge CLK); #1;
    clearReq();
    for (int k = 0; k < 3; k++) begin
      checkOutput("t2WE", bus.WE, 1'b1);
      checkOutput("t2RW", bus.RW, k + 1);
      @(posedge CLK); #1;
    end
    checkOutput("t2Idle", bus.WE, 1'b0);
    // ptr back at 0: slot 0 must beat slot 2
    applyStimulus(0, 5'd11, 32'hA0, 1'b1);
    applyStimulus(2, 5'd10, 32'hA2, 1'b1);
    @(posedge CLK); #1;
    clearReq();
    checkOutput("t2PtrFirst", bus.RW, 11);
    @(posedge CLK); #1;
    checkOutput("t2PtrSecond", bus.RW, 10);
    @(posedge CLK); #1;

    // Starvation bound under continuous reads
    bus.rd_req = 1'b1;
    applyStimulus(1, 5'd9, 32'h99, 1'b1);
    @(posedge CLK); #1;
    clearReq();
    for (int k = 0; k < 6; k++) begin
      checkOutput("t3Grant", bus.rd_grant, (k != 4));
      checkOutput("t3OP", bus.OP, (k == 4));
      @(posedge CLK); #1;
    end

    // Write to r0 is swallowed
    bus.rd_req = 1'b0;
    applyStimulus(2, 5'd0, 32'hBAD, 1'b1);
    @(posedge CLK); #1;
    clearReq();
    for (int k = 0; k < 4; k++) begin
      checkOutput("t4Ready", bus.req_ready, 3'b111);
      checkOutput("t4WE", bus.WE, 1'b0);
      @(posedge CLK); #1;
    end

    // Asynchronous reset drops pending writes
    bus.rd_req = 1'b1;
    applyStimulus(0, 5'd4, 32'h44, 1'b0);
    applyStimulus(1, 5'd6, 32'h66, 1'b0);
    @(posedge CLK); #1;
    clearReq();
    checkOutput("t5Held", bus.req_ready, 3'b100);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("t5RstWE", bus.WE, 1'b0);
    checkOutput("t5RstReady", bus.req_ready, 3'b111);
    checkOutput("t5RstGrant", bus.rd_grant, 1'b0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    bus.rd_req = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    checkOutput("t5After", bus.req_ready, 3'b111);

`ifdef REGFILE_WB_BYPASS_EN
    bus.rd_req = 1'b1;
    applyStimulus(1, 5'd7, 32'h1234, 1'b0);
    @(posedge CLK); #1;
    clearReq();
    bus.rd_ra = 5'd7;
    bus.rd_rb = 5'd0;
    #1;
    checkOutput("t6HitA", bus.byp_a_hit, 1'b1);
    checkOutput("t6DataA", bus.byp_a_data, 32'h1234);
    checkOutput("t6MissB", bus.byp_b_hit, 1'b0);
    bus.rd_ra = 5'd0;
    #1;
    checkOutput("t6ZeroA", bus.byp_a_hit, 1'b0);
    bus.rd_rb = 5'd7;
    applyStimulus(0, 5'd7, 32'hAAAA, 1'b0);
    @(posedge CLK); #1;
    clearReq();
    checkOutput("t6HitB", bus.byp_b_hit, 1'b1);
    checkOutput("t6LowIdx", bus.byp_b_data, 32'hAAAA);
    applyReset();
`endif

    for (int k = 0; k < 20 && expQ.size() != 0; k++) @(posedge CLK);
    #1;
    checkOutput("drainQueue", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
